jt053246_drsched: RTL and testbench

//  Draw-command scheduler between the k053246 object-table scanner and the tile drawer (indr/051937 side).

---
 rtl/jt053246_pkg.sv | 29 ++
 rtl/jt053246_drfifo.sv | 54 +++++
 rtl/jt053246_drsched.sv | 115 +++++++++++
 tb/tb_jt053246_drsched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt053246_pkg.sv
// Shared types for the k053246 draw-command scheduler.
package jt053246_pkg;

  // One tile draw command as produced by the object-table scanner.
  // The listed fields add up to 52 bits; a spare MSB keeps the command word 53 bits wide.
  typedef struct packed {
    logic        spare;
    logic [15:0] code;
    logic [ 9:0] attr;
    logic        hflip;
    logic        vflip;
    logic [ 8:0] hpos;
    logic [ 3:0] ysub;
    logic [ 9:0] hzoom;
    logic        hz_keep;
  } drcmd_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    ACK,
    BUSY
  } state_t;

  // cens spent in ACK without seeing dr_busy before the draw is taken as done
  localparam logic [1:0] ACK_TMO = 2'd2;

endpackage

// File: rtl/jt053246_drfifo.sv
// Draw-command FIFO: dual-port storage, read/write pointers, occupancy count
// and a line-flush input that discards everything not yet popped.
module jt053246_drfifo
  import jt053246_pkg::*;
#(
  parameter int unsigned AW = 3
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  drcmd_t      din,
  output drcmd_t      head,
  output logic [AW:0] cnt,
  output logic        full
);

  drcmd_t        mem [0:2**AW-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nx;

  assign rd_nx = rd_ptr + AW'(pop);
  assign head  = mem[rd_ptr];
  // count can reach exactly 2**AW, which is the only value with the MSB set
  assign full  = cnt[AW];

  // storage write port; a push that coincides with a flush is discarded
  always_ff @(posedge clk) begin
    if (cen && push && !flush) mem[wr_ptr] <= din;
  end

  // pointers and occupancy; a flush collapses the write pointer onto the
  // (possibly just advanced) read pointer so a same-cen pop still completes
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (cen) begin
      rd_ptr <= rd_nx;
      if (flush) begin
        wr_ptr <= rd_nx;
        cnt    <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        cnt    <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

endmodule

// File: rtl/jt053246_drsched.sv
// Draw-command scheduler between the k053246 scanner and the tile drawer.
// Buffers commands, issues them one at a time over dr_start/dr_busy and
// flushes queued commands at every hs rising edge.
// Optional build macro: JT053246_DROPCNT_EN enables the flushed-command counter.
module jt053246_drsched
  import jt053246_pkg::*;
#(
  parameter int unsigned AW = 3
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        hs,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  drcmd_t      cmd,
  output drcmd_t      dr_cmd,
  output logic        dr_start,
  input  logic        dr_busy,
  output logic        idle,
  output logic [15:0] drop_cnt
);

  state_t      state;
  logic [1:0]  ack_cnt;
  logic        hs_l;
  logic        hs_rise;
  logic        push;
  logic        pop;
  logic        flush;
  logic        full;
  logic        empty;
  logic [AW:0] cnt;
  drcmd_t      head;

  assign hs_rise   = hs & ~hs_l;
  assign flush     = cen & hs_rise;
  assign empty     = (cnt == '0);
  assign cmd_ready = ~full;
  assign push      = cen & cmd_valid & ~full;
  assign pop       = cen & (state == LOAD) & ~empty;

  jt053246_drfifo #(
    .AW (AW)
  ) u_fifo (
    .rst   (rst),
    .clk   (clk),
    .cen   (cen),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (cmd),
    .head  (head),
    .cnt   (cnt),
    .full  (full)
  );

  // issue FSM with registered drawer outputs; IDLE does not leave on a
  // flushing cen, otherwise LOAD would find the FIFO already emptied
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dr_cmd   <= '0;
      dr_start <= 1'b0;
      ack_cnt  <= '0;
      hs_l     <= 1'b0;
      idle     <= 1'b1;
    end else if (cen) begin
      hs_l     <= hs;
      dr_start <= 1'b0;
      idle     <= empty && (state == IDLE);
      case (state)
        IDLE: begin
          if (!empty && !hs_rise) state <= LOAD;
        end
        LOAD: begin
          dr_cmd   <= head;
          dr_start <= 1'b1;
          state    <= START;
        end
        START: begin
          ack_cnt <= '0;
          state   <= ACK;
        end
        ACK: begin
          if (dr_busy)                        state   <= BUSY;
          else if (ack_cnt == ACK_TMO - 2'd1) state   <= IDLE;
          else                                ack_cnt <= ack_cnt + 2'd1;
        end
        BUSY: begin
          if (!dr_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JT053246_DROPCNT_EN
  logic [AW:0] drop_n;
  logic [16:0] drop_sum;

  // entries lost to a flush: whatever is queued, minus a same-cen pop, plus a same-cen push
  assign drop_n   = cnt - (AW+1)'(pop) + (AW+1)'(push);
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_n);

  // saturating accumulation of flushed commands
  always_ff @(posedge clk, posedge rst) begin
    if (rst)        drop_cnt <= '0;
    else if (flush) drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_jt053246_drsched.sv
// Self-checking bench for jt053246_drsched (AW=3).
module tb_jt053246_drsched;
  import jt053246_pkg::*;

  logic        rst       = 1'b1;
  logic        clk       = 1'b0;
  logic        cen       = 1'b1;
  logic        hs        = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        dr_busy   = 1'b0;
  drcmd_t      cmd       = '0;
  logic        cmd_ready;
  drcmd_t      dr_cmd;
  logic        dr_start;
  logic        idle;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;

`ifdef JT053246_DROPCNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  jt053246_drsched #(
    .AW (3)
  ) dut (
    .rst       (rst),
    .clk       (clk),
    .cen       (cen),
    .hs        (hs),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .dr_cmd    (dr_cmd),
    .dr_start  (dr_start),
    .dr_busy   (dr_busy),
    .idle      (idle),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic valid;
    logic busy;
    logic ex_start;
    logic ex_idle;
    logic ex_ready;
    logic chk_code;
  } vec_t;

  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic drcmd_t mk(input logic [15:0] code);
    drcmd_t c;
    c       = '0;
    c.code  = code;
    c.attr  = code[9:0];
    c.hpos  = 9'h0A0;
    c.hzoom = 10'h040;
    return c;
  endfunction

  task automatic push1(input logic [15:0] code);
    cmd       = mk(code);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  // Drawer model: counts dr_start pulses, checks order against exp_q and
  // spacing; optionally answers each start with a few busy cens.
  task automatic observe(input int max_cyc, input bit respond, input string tag);
    int n = 0;
    int last = -100;
    int busy_left = 0;
    int n_exp;
    logic [15:0] want;
    n_exp = exp_q.size();
    for (int c = 0; c < max_cyc; c++) begin
      tick;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) dr_busy = 1'b0;
      end
      if (dr_start) begin
        n++;
        want = 16'hxxxx;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        chk({tag, "_code"}, 64'(dr_cmd.code), 64'(want));
        if (last >= 0)
          chk({tag, "_spacing"}, 64'((c - last >= 4) && (respond || c - last <= 5)), 64'd1);
        last = c;
        if (respond) begin
          dr_busy   = 1'b1;
          busy_left = 3;
        end
      end
    end
    dr_busy = 1'b0;
    chk({tag, "_starts"}, 64'(n), 64'(n_exp));
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];

    // reset state
    repeat (2) tick;
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_start", 64'(dr_start), 64'd0);
    chk("rst_idle",  64'(idle), 64'd1);
    chk("rst_drcmd", 64'(dr_cmd), 64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);
    rst = 1'b0;
    tick;

    // test 1: single command, drawer busy 5 cens
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    cmd = mk(16'h1234);
    for (int i = 0; i < 10; i++) begin
      cmd_valid = vt[i].valid;
      dr_busy   = vt[i].busy;
      tick;
      chk($sformatf("t1_start_%0d", i), 64'(dr_start), 64'(vt[i].ex_start));
      chk($sformatf("t1_idle_%0d", i),  64'(idle), 64'(vt[i].ex_idle));
      chk($sformatf("t1_ready_%0d", i), 64'(cmd_ready), 64'(vt[i].ex_ready));
      if (vt[i].chk_code) begin
        chk($sformatf("t1_code_%0d", i), 64'(dr_cmd.code), 64'h1234);
        chk($sformatf("t1_hpos_%0d", i), 64'(dr_cmd.hpos), 64'h0A0);
      end
    end
    cmd_valid = 1'b0;
    dr_busy   = 1'b0;

    // test 2: fill all 8 entries behind a busy draw; 9th refused
    dr_busy = 1'b1;
    push1(16'h0100);
    repeat (4) tick;
    for (int i = 0; i < 8; i++) begin
      cmd       = mk(16'h0200 + 16'(i));
      cmd_valid = 1'b1;
      tick;
      chk($sformatf("t2_ready_%0d", i), 64'(cmd_ready), (i == 7) ? 64'd0 : 64'd1);
    end
    cmd = mk(16'h02FF);
    repeat (2) tick;
    chk("t2_ready_9th", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0200 + 16'(i));
    dr_busy = 1'b0;
    observe(100, 1'b1, "t2");
    chk("t2_idle", 64'(idle), 64'd1);
    chk("t2_ready_end", 64'(cmd_ready), 64'd1);

    // test 3: drawer never raises busy -> ACK timeout, no deadlock
    exp_q.push_back(16'h0301);
    exp_q.push_back(16'h0302);
    push1(16'h0301);
    push1(16'h0302);
    observe(40, 1'b0, "t3");
    chk("t3_idle", 64'(idle), 64'd1);

    // test 4: 5 queued behind an in-flight draw, then a line flush
    dr_busy = 1'b1;
    push1(16'h0400);
    repeat (4) tick;
    for (int i = 1; i <= 5; i++) push1(16'h0400 + 16'(i));
    hs = 1'b1;
    tick;
    hs = 1'b0;
    chk("t4_ready", 64'(cmd_ready), 64'd1);
    chk("t4_inflight", 64'(dr_cmd.code), 64'h0400);
    tick;
    dr_busy = 1'b0;
    observe(30, 1'b0, "t4");
    chk("t4_idle", 64'(idle), 64'd1);
    chk("t4_drop", 64'(drop_cnt), DROP_EN ? 64'd5 : 64'd0);

    // test 5: push and hs edge on the same cen into an empty FIFO
    cmd       = mk(16'h0500);
    cmd_valid = 1'b1;
    hs        = 1'b1;
    tick;
    cmd_valid = 1'b0;
    hs        = 1'b0;
    observe(20, 1'b0, "t5");
    chk("t5_drop", 64'(drop_cnt), DROP_EN ? 64'd6 : 64'd0);
    chk("t5_idle", 64'(idle), 64'd1);

    // cen low: nothing is accepted
    cen       = 1'b0;
    cmd       = mk(16'h05C0);
    cmd_valid = 1'b1;
    repeat (3) tick;
    cmd_valid = 1'b0;
    cen       = 1'b1;
    observe(15, 1'b0, "tcen");

    // test 6: reset in BUSY with 3 queued
    dr_busy = 1'b1;
    push1(16'h0600);
    repeat (4) tick;
    for (int i = 1; i <= 3; i++) push1(16'h0600 + 16'(i));
    rst = 1'b1;
    #1;
    chk("t6_ready", 64'(cmd_ready), 64'd1);
    chk("t6_drcmd", 64'(dr_cmd), 64'd0);
    chk("t6_start", 64'(dr_start), 64'd0);
    chk("t6_idle",  64'(idle), 64'd1);
    chk("t6_drop",  64'(drop_cnt), 64'd0);
    dr_busy = 1'b0;
    tick;
    chk("t6_start_rst", 64'(dr_start), 64'd0);
    rst = 1'b0;
    tick;
    push1(16'h06AA);
    tick;
    chk("t6_lat1", 64'(dr_start), 64'd0);
    tick;
    chk("t6_lat2", 64'(dr_start), 64'd1);
    chk("t6_code", 64'(dr_cmd.code), 64'h06AA);
    observe(25, 1'b0, "t6");
    chk("t6_idle_end", 64'(idle), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
